muldiv_iterative: RTL and testbench
===================================

// Module: muldiv_iterative
// PURPOSE
//  Iterative RV32M multiply/divide execute unit beside the ALU, downstream of the register file.
//  Takes rs1/rs2 read data plus funct3 and rd, computes over ~33 cycles and returns the
//  write-back value and rd for the register-file write port. The core stalls while busy=1.
// PARAMETERS
//  WIDTH  32  operand/result width; only 32 is supported and verified
// PORTS
//  clk_in     in   1      clock, all state updates on the rising edge
//  reset      in   1      synchronous, active-low reset (0 = reset)
//  start      in   1      request; sampled only while in IDLE
//  funct3     in   3      0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
//  operand_a  in   WIDTH  rs1 value (read_data_1)
//  operand_b  in   WIDTH  rs2 value (read_data_2)
//  rd_in      in   5      destination register index
//  busy       out  1      1 whenever state != IDLE
//  done       out  1      one-cycle pulse; result and rd_out valid in this cycle
//  result     out  WIDTH  write-back data; holds until the next accepted start
//  rd_out     out  5      rd captured at start; held with result
// BEHAVIOUR
//  Clock and reset: one clock, clk_in. Reset is synchronous, active-low.
//  Reset (reset=0 at an edge): state=IDLE, busy=0, done=0, result=0, rd_out=0, all internal regs 0.
//    Reset has priority over everything. An operation aborted mid-flight never pulses done.
//  FSM IDLE -> CALC -> DONE -> IDLE.
//  IDLE:
//    - start=1 at edge k: capture funct3, rd_in, |operands|, and result sign flags.
//    - Operand values are ignored after edge k.
//    - Normal case: go to CALC with count=0.
//    - Special divide cases go straight to DONE at edge k, with result loaded (done in cycle k+1):
//        divisor==0: DIV/DIVU quotient = 0xFFFFFFFF; REM/REMU result = operand_a.
//        DIV/REM with a=0x80000000, b=0xFFFFFFFF: DIV = 0x80000000, REM = 0.
//  CALC: one iteration per edge, 32 iterations (edges k+1..k+32).
//    - Multiply: shift-add over a 64-bit product of magnitudes. MULHU uses unsigned operands.
//      MULH uses both signed. MULHSU uses a signed, b unsigned.
//    - Divide: restoring, one quotient bit per edge, on magnitudes (unsigned for DIVU/REMU).
//    - At edge k+32: apply sign correction, load result, go to DONE.
//      Product negated iff exactly one signed operand is negative.
//      Quotient negated iff signs differ.
//      Remainder takes the sign of the dividend.
//      MUL returns product[31:0]; MULH* return product[63:32].
//  DONE: done=1 for exactly one cycle (cycle k+33 for the normal path), busy=1. Next edge goes to IDLE.
//  Latency: start at edge k -> done in the cycle after edge k+32 (k+1 for special cases).
//    Next start is accepted at the first edge with state=IDLE.
//  start while busy=1 is ignored; no queueing, no error flag.
//  start held high continuously: a new operation begins at each IDLE edge
//    (back-to-back throughput = 34 cycles).
//  rd_in==0: operation runs normally; write suppression for x0 is the register file's job.
//  done never asserts in the same cycle as busy=0.
// TESTING
//  1 MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 33 cycles after start edge; rd_out=rd_in.
//  2 MULH a=b=0x80000000 -> 0x40000000.
//    MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
//    MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
//  3 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD.
//    REM same operands -> 0xFFFFFFFF.
//    DIVU 100/7 -> 14; REMU 100/7 -> 2.
//  4 DIVU a=0x1234, b=0 -> 0xFFFFFFFF with done the cycle after start.
//    REM a=0x1234, b=0 -> 0x1234.
//    DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 (fast path).
//  5 Drive start, change operands and pulse start again at cycle 5 of CALC
//    -> ignored; first result unaffected; exactly one done pulse.
//  6 reset=0 at CALC cycle 10 -> next cycle busy=0, done=0, result=0; no done pulse.
//    A fresh MUL 3*5 after release returns 15.

Source files
------------

// File: rtl/muldiv_iterative_if.sv
// muldiv_iterative_if: request/response bundle for the iterative multiply/divide unit
//   start/funct3/operand_a/operand_b/rd_in : request from the core (master -> slave)
//   busy/done/result/rd_out                : status and write-back (slave -> master)
interface muldiv_iterative_if #(parameter int WIDTH = 32);
    logic             start;
    logic [2:0]       funct3;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [4:0]       rd_in;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       rd_out;
    modport master (output start, funct3, operand_a, operand_b, rd_in,
                    input  busy, done, result, rd_out);
    modport slave  (input  start, funct3, operand_a, operand_b, rd_in,
                    output busy, done, result, rd_out);
endinterface

// File: rtl/muldiv_iterative.sv
// muldiv_iterative: iterative RV32M multiply/divide unit, one bit per cycle
//   clk_in : clock, rising edge
//   reset  : synchronous, active-low
//   bus    : slave side of muldiv_iterative_if (request in, busy/done/result/rd_out out)
module muldiv_iterative #(parameter int WIDTH = 32) (
    input logic               clk_in,
    input logic               reset,
    muldiv_iterative_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [1:0] IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2;
    logic [1:0]         state;
    logic [2:0]         op;
    logic               neg;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   m;
    logic [WIDTH-1:0]   res_q;
    logic [4:0]         rd_q;
    logic               sa, sb, div_zero, ovf, fast;
    logic [WIDTH-1:0]   a_mag, b_mag, fast_res, div_sel, div_fix, res_next;
    logic [WIDTH:0]     mul_sum, div_trial;
    logic [2*WIDTH-1:0] mul_next, div_next, p_next, prod_fix;
    // Request decode: which operands are signed, magnitudes, and the divide shortcuts
    always_comb begin
        sa       = bus.operand_a[WIDTH-1] & (bus.funct3 inside {3'd1, 3'd2, 3'd4, 3'd6});
        sb       = bus.operand_b[WIDTH-1] & (bus.funct3 inside {3'd1, 3'd4, 3'd6});
        a_mag    = sa ? -bus.operand_a : bus.operand_a;
        b_mag    = sb ? -bus.operand_b : bus.operand_b;
        div_zero = bus.operand_b == '0;
        ovf      = bus.operand_a == {1'b1, {(WIDTH-1){1'b0}}} && bus.operand_b == '1;
        fast     = bus.funct3[2] & (div_zero | (~bus.funct3[0] & ovf));
        // Signed overflow returns the dividend itself as quotient, which is 0x80000000
        fast_res = div_zero ? (bus.funct3[1] ? bus.operand_a : '1)
                            : (bus.funct3[1] ? '0 : bus.operand_a);
    end
    // One iteration: p holds {accumulator, multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : '0);
        mul_next  = {mul_sum, p[WIDTH-1:1]};
        div_trial = p[2*WIDTH-1:WIDTH-1] - {1'b0, m};
        div_next  = div_trial[WIDTH] ? {p[2*WIDTH-2:0], 1'b0}
                                     : {div_trial[WIDTH-1:0], p[WIDTH-2:0], 1'b1};
        p_next    = op[2] ? div_next : mul_next;
        prod_fix  = neg ? -p_next : p_next;
        div_sel   = op[1] ? p_next[2*WIDTH-1:WIDTH] : p_next[WIDTH-1:0];
        div_fix   = neg ? -div_sel : div_sel;
        res_next  = op[2] ? div_fix
                          : (op[1:0] == 2'b00 ? prod_fix[WIDTH-1:0] : prod_fix[2*WIDTH-1:WIDTH]);
    end
    always_ff @(posedge clk_in) begin
        if (!reset) begin
            state <= IDLE;
            op    <= '0;
            neg   <= 1'b0;
            count <= '0;
            p     <= '0;
            m     <= '0;
            res_q <= '0;
            rd_q  <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op    <= bus.funct3;
                    rd_q  <= bus.rd_in;
                    // Remainder follows the dividend; product and quotient follow the sign mix
                    neg   <= (bus.funct3[2] & bus.funct3[1]) ? sa : sa ^ sb;
                    count <= '0;
                    p     <= {{WIDTH{1'b0}}, bus.funct3[2] ? a_mag : b_mag};
                    m     <= bus.funct3[2] ? b_mag : a_mag;
                    if (fast) res_q <= fast_res;
                    state <= fast ? DONE : CALC;
                end
                CALC: begin
                    p     <= p_next;
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        res_q <= res_next;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign bus.busy   = state != IDLE;
    assign bus.done   = state == DONE;
    assign bus.result = res_q;
    assign bus.rd_out = rd_q;
endmodule

// File: tb/tb_muldiv_iterative.sv
// tb_muldiv_iterative: directed self-checking bench for muldiv_iterative
module tb_muldiv_iterative;
    logic clk = 1'b0;
    logic reset;
    int passed = 0;
    int failed = 0;
    int total = 0;
    always #5 clk = ~clk;
    muldiv_iterative_if #(.WIDTH(32)) bus ();
    muldiv_iterative #(.WIDTH(32)) dut (.clk_in(clk), .reset(reset), .bus(bus));
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Issue one request, wait (bounded) for done, return result/rd and the cycle of done
    // relative to the start edge (1 = cycle right after it), then step back into IDLE.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res,
                          output logic [4:0] rdo, output int lat);
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct3 = f;
        bus.operand_a = a;
        bus.operand_b = b;
        bus.rd_in = rd;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.operand_a = ~a;
        bus.operand_b = ~b;
        bus.rd_in = ~rd;
        lat = 1;
        while (!bus.done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        res = bus.result;
        rdo = bus.rd_out;
        @(posedge clk);
        #1;
    endtask
    initial begin
        logic [31:0] r;
        logic [4:0] rdo;
        int lat;
        int pulses;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.funct3 = '0;
        bus.operand_a = '0;
        bus.operand_b = '0;
        bus.rd_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        check("rst_rd", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd17, r, rdo, lat);
        check("mul", r, 32'hFFFFFFEB);
        check("mul_lat", 32'(lat), 32'd33);
        check("mul_rd", 32'(rdo), 32'd17);
        run_op(3'd1, 32'h80000000, 32'h80000000, 5'd1, r, rdo, lat);
        check("mulh", r, 32'h40000000);
        run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, r, rdo, lat);
        check("mulhsu", r, 32'hFFFFFFFF);
        run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd3, r, rdo, lat);
        check("mulhu", r, 32'hFFFFFFFE);
        run_op(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4, r, rdo, lat);
        check("div", r, 32'hFFFFFFFD);
        check("div_lat", 32'(lat), 32'd33);
        run_op(3'd6, 32'hFFFFFFF9, 32'd2, 5'd5, r, rdo, lat);
        check("rem", r, 32'hFFFFFFFF);
        run_op(3'd5, 32'd100, 32'd7, 5'd6, r, rdo, lat);
        check("divu", r, 32'd14);
        run_op(3'd7, 32'd100, 32'd7, 5'd7, r, rdo, lat);
        check("remu", r, 32'd2);
        run_op(3'd5, 32'h1234, 32'd0, 5'd8, r, rdo, lat);
        check("divu_zero", r, 32'hFFFFFFFF);
        check("divu_zero_lat", 32'(lat), 32'd1);
        check("divu_zero_rd", 32'(rdo), 32'd8);
        run_op(3'd6, 32'h1234, 32'd0, 5'd9, r, rdo, lat);
        check("rem_zero", r, 32'h1234);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd10, r, rdo, lat);
        check("div_ovf", r, 32'h80000000);
        check("div_ovf_lat", 32'(lat), 32'd1);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd11, r, rdo, lat);
        check("rem_ovf", r, 32'd0);
        // start pulsed again mid-calculation must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct3 = 3'd0;
        bus.operand_a = 32'd6;
        bus.operand_b = 32'd7;
        bus.rd_in = 5'd12;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct3 = 3'd4;
        bus.operand_a = 32'd100;
        bus.operand_b = 32'd100;
        bus.rd_in = 5'd13;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        pulses = 0;
        r = '0;
        rdo = '0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                pulses++;
                r = bus.result;
                rdo = bus.rd_out;
            end
        end
        check("busy_start_result", r, 32'd42);
        check("busy_start_rd", 32'(rdo), 32'd12);
        check("busy_start_pulses", 32'(pulses), 32'd1);
        // reset in the middle of a calculation aborts it
        @(negedge clk);
        bus.start = 1'b1;
        bus.funct3 = 3'd0;
        bus.operand_a = 32'd1000;
        bus.operand_b = 32'd1000;
        bus.rd_in = 5'd4;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_done", 32'(bus.done), 32'd0);
        check("abort_result", bus.result, 32'd0);
        check("abort_rd", 32'(bus.rd_out), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) pulses++;
        end
        check("abort_pulses", 32'(pulses), 32'd0);
        run_op(3'd0, 32'd3, 32'd5, 5'd0, r, rdo, lat);
        check("mul_after_reset", r, 32'd15);
        check("mul_after_reset_lat", 32'(lat), 32'd33);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
